button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles required to accept a new button level.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 50000000, meaning cycles from the first increment pulse to the first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 10000000, meaning cycles between subsequent auto-repeat pulses.
REQ-004 The block SHALL have parameter REPEAT_EN, default 1, meaning increment auto-repeat is enabled (0 means a single pulse per press).
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock; all state SHALL be updated on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have ports start, stop and increment, inputs, 1 bit each: raw, asynchronous, bouncing push-button levels, with 1 meaning pressed.
REQ-008 The block SHALL have ports start_p, stop_p and inc_p, outputs, 1 bit each: single-cycle, registered command pulses for the downstream stopwatch control.
REQ-009 The block SHALL have port held, output, 3 bits: debounced button levels, {increment, stop, start} in bits [2:0].

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each button SHALL have its own debounce counter and debounced level db.
- Synchronized level != db: the counter increments.
- Synchronized level == db: the counter clears to 0.
- When DEBOUNCE_CYCLES consecutive mismatches complete, db takes the new level and the counter clears.
REQ-012 Latency: for a clean level change, db and held SHALL update on edge DEBOUNCE_CYCLES+2, counting the first edge that samples the new raw level as edge 1.
REQ-013 start_p and stop_p SHALL be high for exactly one cycle, on the same edge their db rises 0->1.
REQ-014 A db falling 1->0 SHALL produce no pulse.
REQ-015 If start and stop db rise on the same edge, stop_p SHALL assert and start_p SHALL stay 0 (stop wins).
REQ-016 Increment SHALL be handled by an FSM with states INC_IDLE, INC_DELAY and INC_REPEAT, plus a repeat timer.
REQ-017 INC_IDLE, on increment db rising: inc_p=1 for one cycle, timer cleared, next state INC_DELAY (or stay INC_IDLE waiting for release if REPEAT_EN=0).
REQ-018 INC_DELAY: the timer counts each cycle; REPEAT_DELAY cycles after the entry pulse, inc_p=1, the timer clears and the FSM goes to INC_REPEAT.
REQ-019 INC_REPEAT: inc_p=1 every REPEAT_PERIOD cycles, with the timer clearing at each pulse.
REQ-020 In any state, increment db low SHALL force INC_IDLE and clear the timer, with no pulse on that edge (release beats a coinciding repeat).
REQ-021 The timer width SHALL be sized to hold max(REPEAT_DELAY, REPEAT_PERIOD) and SHALL never wrap.
REQ-022 Debounce counter width SHALL be sized to hold DEBOUNCE_CYCLES and SHALL never wrap.
REQ-023 All outputs SHALL be registered, with no combinational path from raw inputs to outputs.

Reset
REQ-024 While rst=1, all synchronizer flops, db levels, counters and the timer SHALL clear; the FSM SHALL go to INC_IDLE; start_p, stop_p, inc_p and held SHALL all be 0.
REQ-025 rst SHALL override every other event on the same edge, including mid-debounce and mid-repeat.
REQ-026 A button still held when rst deasserts SHALL be treated as a new press: a pulse DEBOUNCE_CYCLES+2 edges after the first post-reset edge.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8; edge 1 = first edge sampling the stimulus)
REQ-027 Clean press: start high for 12 cycles then low -> start_p=1 only at edge 6; held[0] rises at edge 6 and falls 6 edges after release; no second pulse.
REQ-028 Bounce: start toggles every cycle for 7 cycles, then low -> start_p never asserts; held[0] stays 0.
REQ-029 Auto-repeat: increment high for edges 1-56 -> inc_p at edges 6, 26, 34, 42, 50 and 58 only; held[2] falls at edge 62; FSM ends in INC_IDLE.
REQ-030 Simultaneous press: start and stop rise in the same cycle -> stop_p=1 at edge 6; start_p stays 0 throughout.
REQ-031 Reset mid-debounce: start held high; rst=1 sampled at edge 4 only -> all outputs 0 after edge 4; start_p=1 at edge 10.
REQ-032 REPEAT_EN=0: increment held for 60 cycles -> exactly one inc_p, at edge 6.

Source files
------------

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Synchronizes and debounces three push-buttons. Produces
//                start/stop command pulses and an auto-repeating increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned REPEAT_EN       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       increment,
  output logic       start_p,
  output logic       stop_p,
  output logic       inc_p,
  output logic [2:0] held
);

  localparam int unsigned c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned c_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned c_TMR_W   = $clog2(c_RPT_MAX + 1);

  localparam logic [c_DB_W-1:0]  c_DB_LAST     = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_DELAY_LAST  = c_TMR_W'(REPEAT_DELAY - 1);
  localparam logic [c_TMR_W-1:0] c_PERIOD_LAST = c_TMR_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    INC_IDLE   = 2'd0,
    INC_DELAY  = 2'd1,
    INC_REPEAT = 2'd2
  } inc_state_t;

  logic [2:0] w_raw;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] w_db;
  logic [2:0] w_db_next;
  logic [2:0] w_rise;

  inc_state_t         r_state;
  inc_state_t         w_state_next;
  logic [c_TMR_W-1:0] r_timer;
  logic [c_TMR_W-1:0] w_timer_next;
  logic               w_inc_pulse;

  assign w_raw = {increment, stop, start};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // w_db_next is the level each button takes on this edge, so pulses can be
  // registered on the very edge the debounced level changes.
  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic              r_lvl;
    logic [c_DB_W-1:0] r_cnt;
    logic              w_done;

    assign w_done         = (r_sync2[gi] != r_lvl) && (r_cnt == c_DB_LAST);
    assign w_db[gi]       = r_lvl;
    assign w_db_next[gi]  = w_done ? r_sync2[gi] : r_lvl;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_lvl <= 1'b0;
        r_cnt <= '0;
      end else if (r_sync2[gi] == r_lvl) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_lvl <= r_sync2[gi];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_rise = w_db_next & ~w_db;
  assign held   = w_db;

  always_ff @(posedge clk) begin
    if (rst) begin
      start_p <= 1'b0;
      stop_p  <= 1'b0;
      inc_p   <= 1'b0;
    end else begin
      start_p <= w_rise[0] & ~w_rise[1];
      stop_p  <= w_rise[1];
      inc_p   <= w_inc_pulse;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INC_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
    end
  end

  // Release is checked first so it beats a repeat pulse falling on the same edge.
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_inc_pulse  = 1'b0;
    if (!w_db_next[2]) begin
      w_state_next = INC_IDLE;
      w_timer_next = '0;
    end else begin
      case (r_state)
        INC_IDLE: begin
          if (w_rise[2]) begin
            w_inc_pulse  = 1'b1;
            w_timer_next = '0;
            w_state_next = (REPEAT_EN != 0) ? INC_DELAY : INC_IDLE;
          end
        end
        INC_DELAY: begin
          if (r_timer == c_DELAY_LAST) begin
            w_inc_pulse  = 1'b1;
            w_timer_next = '0;
            w_state_next = INC_REPEAT;
          end else begin
            w_timer_next = r_timer + 1'b1;
          end
        end
        INC_REPEAT: begin
          if (r_timer == c_PERIOD_LAST) begin
            w_inc_pulse  = 1'b1;
            w_timer_next = '0;
          end else begin
            w_timer_next = r_timer + 1'b1;
          end
        end
        default: begin
          w_state_next = INC_IDLE;
          w_timer_next = '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Self-checking bench with a window-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       increment = 1'b0;
  logic       start_p, stop_p, inc_p;
  logic [2:0] held;
  logic       nr_start_p, nr_stop_p, nr_inc_p;
  logic [2:0] nr_held;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .increment(increment),
    .start_p(start_p), .stop_p(stop_p), .inc_p(inc_p), .held(held)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(0)
  ) dut_nr (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .increment(increment),
    .start_p(nr_start_p), .stop_p(nr_stop_p), .inc_p(nr_inc_p), .held(nr_held)
  );

  // Model: the synchronizer is a two-sample delay; a button flips once the
  // last DB synchronized samples all differ from its current level.
  logic [2:0] m_raw_q[$];
  logic [2:0] m_sync_q[$];
  logic [2:0] m_db = 3'b000;
  logic       m_start_p = 1'b0, m_stop_p = 1'b0, m_inc_p = 1'b0, m_inc_nr = 1'b0;
  int         m_edge = 0;
  int         m_inc_t0 = -1;

  function automatic void model_edge(input logic [2:0] raw, input logic r);
    logic [2:0] s, nxt, rise;
    int k;
    if (r) begin
      m_raw_q.delete();
      m_sync_q.delete();
      m_db = 3'b000;
      m_start_p = 1'b0; m_stop_p = 1'b0; m_inc_p = 1'b0; m_inc_nr = 1'b0;
      m_edge = 0;
      m_inc_t0 = -1;
      return;
    end
    m_edge++;
    s = (m_raw_q.size() >= 2) ? m_raw_q[0] : 3'b000;
    m_raw_q.push_back(raw);
    if (m_raw_q.size() > 2) void'(m_raw_q.pop_front());
    m_sync_q.push_back(s);
    if (m_sync_q.size() > DB) void'(m_sync_q.pop_front());
    nxt = m_db;
    for (int b = 0; b < 3; b++) begin
      bit all_diff;
      all_diff = (m_sync_q.size() == DB);
      foreach (m_sync_q[i]) if (m_sync_q[i][b] == m_db[b]) all_diff = 1'b0;
      if (all_diff) nxt[b] = ~m_db[b];
    end
    rise = nxt & ~m_db;
    m_start_p = rise[0] & ~rise[1];
    m_stop_p  = rise[1];
    if (rise[2]) m_inc_t0 = m_edge;
    if (!nxt[2]) m_inc_t0 = -1;
    k = m_edge - m_inc_t0;
    m_inc_p  = nxt[2] && (m_inc_t0 >= 0) && ((k == 0) || ((k >= RD) && ((k - RD) % RP == 0)));
    m_inc_nr = nxt[2] && (m_inc_t0 >= 0) && (k == 0);
    m_db = nxt;
  endfunction

  task automatic step(input logic [2:0] raw, input logic r);
    {increment, stop, start} = raw;
    rst = r;
    @(posedge clk);
    #1;
    model_edge(raw, r);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(3'($urandom), 1'b1);
      if ({start_p, stop_p, inc_p, held, nr_start_p, nr_stop_p, nr_inc_p, nr_held} !== 12'h000) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", i,
                 {start_p, stop_p, inc_p, held, nr_start_p, nr_stop_p, nr_inc_p, nr_held}, 12'h000);
      end
      total++;
    end
  endtask

  task automatic test_idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(3'b000, 1'b0);
      if ({start_p, stop_p, inc_p, held, nr_start_p, nr_stop_p, nr_inc_p, nr_held} !==
          {m_start_p, m_stop_p, m_inc_p, m_db, m_start_p, m_stop_p, m_inc_nr, m_db}) begin
        bad++;
        $display("FAIL idle cyc=%0d got=%b exp=%b", i,
                 {start_p, stop_p, inc_p, held, nr_start_p, nr_stop_p, nr_inc_p, nr_held},
                 {m_start_p, m_stop_p, m_inc_p, m_db, m_start_p, m_stop_p, m_inc_nr, m_db});
      end
      total++;
    end
  endtask

  task automatic test_clean_press();
    int n_pulse = 0, pulse_edge = -1, rise_edge = -1, fall_edge = -1;
    for (int e = 1; e <= 24; e++) begin
      step((e <= 12) ? 3'b001 : 3'b000, 1'b0);
      if (start_p) begin n_pulse++; pulse_edge = e; end
      if (held[0] && rise_edge < 0) rise_edge = e;
      if (!held[0] && rise_edge > 0 && fall_edge < 0) fall_edge = e;
      if ({start_p, stop_p, inc_p, held} !== {m_start_p, m_stop_p, m_inc_p, m_db}) begin
        bad++;
        $display("FAIL clean_press edge=%0d got=%b exp=%b", e,
                 {start_p, stop_p, inc_p, held}, {m_start_p, m_stop_p, m_inc_p, m_db});
      end
      total++;
    end
    if (n_pulse !== 1 || pulse_edge !== 6 || rise_edge !== 6 || fall_edge !== 18) begin
      bad++;
      $display("FAIL clean_press_timing got pulses=%0d pulse@%0d rise@%0d fall@%0d exp 1,6,6,18",
               n_pulse, pulse_edge, rise_edge, fall_edge);
    end
    total++;
  endtask

  task automatic test_bounce();
    int n_pulse = 0, n_held = 0;
    for (int e = 1; e <= 16; e++) begin
      step((e <= 7 && (e % 2 == 1)) ? 3'b001 : 3'b000, 1'b0);
      n_pulse += int'(start_p);
      n_held  += int'(held[0]);
      if ({start_p, stop_p, inc_p, held} !== {m_start_p, m_stop_p, m_inc_p, m_db}) begin
        bad++;
        $display("FAIL bounce edge=%0d got=%b exp=%b", e,
                 {start_p, stop_p, inc_p, held}, {m_start_p, m_stop_p, m_inc_p, m_db});
      end
      total++;
    end
    if (n_pulse !== 0 || n_held !== 0) begin
      bad++;
      $display("FAIL bounce_quiet got pulses=%0d held_cycles=%0d exp 0,0", n_pulse, n_held);
    end
    total++;
  endtask

  task automatic test_auto_repeat();
    int got_edges[$];
    int exp_edges[6] = '{6, 26, 34, 42, 50, 58};
    int fall_edge = -1;
    for (int e = 1; e <= 72; e++) begin
      step((e <= 56) ? 3'b100 : 3'b000, 1'b0);
      if (inc_p) got_edges.push_back(e);
      if (!held[2] && e > 6 && fall_edge < 0) fall_edge = e;
      if ({start_p, stop_p, inc_p, held, nr_inc_p} !== {m_start_p, m_stop_p, m_inc_p, m_db, m_inc_nr}) begin
        bad++;
        $display("FAIL auto_repeat edge=%0d got=%b exp=%b", e,
                 {start_p, stop_p, inc_p, held, nr_inc_p}, {m_start_p, m_stop_p, m_inc_p, m_db, m_inc_nr});
      end
      total++;
    end
    if (got_edges.size() !== 6) begin
      bad++;
      $display("FAIL auto_repeat_count got=%0d exp=6", got_edges.size());
    end else begin
      foreach (exp_edges[i]) if (got_edges[i] !== exp_edges[i]) begin
        bad++;
        $display("FAIL auto_repeat_edge idx=%0d got=%0d exp=%0d", i, got_edges[i], exp_edges[i]);
      end
    end
    total++;
    if (fall_edge !== 62) begin
      bad++;
      $display("FAIL auto_repeat_release got=%0d exp=62", fall_edge);
    end
    total++;
  endtask

  task automatic test_simultaneous();
    int n_start = 0, stop_edge = -1;
    for (int e = 1; e <= 16; e++) begin
      step((e <= 10) ? 3'b011 : 3'b000, 1'b0);
      n_start += int'(start_p);
      if (stop_p) stop_edge = e;
      if ({start_p, stop_p, inc_p, held} !== {m_start_p, m_stop_p, m_inc_p, m_db}) begin
        bad++;
        $display("FAIL simultaneous edge=%0d got=%b exp=%b", e,
                 {start_p, stop_p, inc_p, held}, {m_start_p, m_stop_p, m_inc_p, m_db});
      end
      total++;
    end
    if (n_start !== 0 || stop_edge !== 6) begin
      bad++;
      $display("FAIL stop_wins got start_pulses=%0d stop@%0d exp 0,6", n_start, stop_edge);
    end
    total++;
  endtask

  task automatic test_reset_mid_debounce();
    int pulse_edge = -1;
    for (int e = 1; e <= 16; e++) begin
      step(3'b001, e == 4);
      if (start_p) pulse_edge = e;
      if (e == 4 && {start_p, stop_p, inc_p, held} !== 6'b0) begin
        bad++;
        $display("FAIL reset_mid_outputs got=%b exp=%b", {start_p, stop_p, inc_p, held}, 6'b0);
      end
      if ({start_p, stop_p, inc_p, held} !== {m_start_p, m_stop_p, m_inc_p, m_db}) begin
        bad++;
        $display("FAIL reset_mid edge=%0d got=%b exp=%b", e,
                 {start_p, stop_p, inc_p, held}, {m_start_p, m_stop_p, m_inc_p, m_db});
      end
      total++;
    end
    if (pulse_edge !== 10) begin
      bad++;
      $display("FAIL reset_mid_pulse got=%0d exp=10", pulse_edge);
    end
    total++;
  endtask

  task automatic test_no_repeat();
    int n_pulse = 0, pulse_edge = -1;
    for (int e = 1; e <= 70; e++) begin
      step((e <= 60) ? 3'b100 : 3'b000, 1'b0);
      if (nr_inc_p) begin n_pulse++; pulse_edge = e; end
      if ({nr_start_p, nr_stop_p, nr_inc_p, nr_held} !== {m_start_p, m_stop_p, m_inc_nr, m_db}) begin
        bad++;
        $display("FAIL no_repeat edge=%0d got=%b exp=%b", e,
                 {nr_start_p, nr_stop_p, nr_inc_p, nr_held}, {m_start_p, m_stop_p, m_inc_nr, m_db});
      end
      total++;
    end
    if (n_pulse !== 1 || pulse_edge !== 6) begin
      bad++;
      $display("FAIL no_repeat_single got pulses=%0d at=%0d exp 1,6", n_pulse, pulse_edge);
    end
    total++;
  endtask

  task automatic test_random(input int n_seg);
    logic [2:0] lvl, raw;
    int len, bnc;
    logic r;
    for (int s = 0; s < n_seg; s++) begin
      lvl = 3'($urandom);
      len = $urandom_range(1, 40);
      bnc = $urandom_range(0, 5);
      for (int j = 0; j < len; j++) begin
        raw = (j < bnc) ? (lvl ^ 3'($urandom)) : lvl;
        r   = ($urandom_range(0, 199) == 0);
        step(raw, r);
        if ({start_p, stop_p, inc_p, held, nr_start_p, nr_stop_p, nr_inc_p, nr_held} !==
            {m_start_p, m_stop_p, m_inc_p, m_db, m_start_p, m_stop_p, m_inc_nr, m_db}) begin
          bad++;
          $display("FAIL random seg=%0d cyc=%0d got=%b exp=%b", s, j,
                   {start_p, stop_p, inc_p, held, nr_start_p, nr_stop_p, nr_inc_p, nr_held},
                   {m_start_p, m_stop_p, m_inc_p, m_db, m_start_p, m_stop_p, m_inc_nr, m_db});
        end
        total++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle(4);
    test_clean_press();
    test_idle(8);
    test_bounce();
    test_idle(8);
    test_auto_repeat();
    test_idle(8);
    test_simultaneous();
    test_idle(8);
    test_reset_mid_debounce();
    test_idle(8);
    test_no_repeat();
    test_idle(8);
    test_random(150);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
